// File: rtl/dbg_run_ctrl_pkg.sv
// Shared encodings for the debug run/halt sequencer: host ops, halt causes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dbg_run_ctrl_pkg;

  localparam int CNT_W_DEF = 32;

  // Host command opcodes as carried on cmd_op.
  typedef enum logic [1:0] {
    OP_RUN  = 2'd0,
    OP_STEP = 2'd1,
    OP_HALT = 2'd2,
    OP_RSVD = 2'd3
  } cmd_op_e;

  // Halt cause reported to the probe with each halt event.
  typedef enum logic [2:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_EBREAK    = 3'd1,
    CAUSE_INVALID   = 3'd2,
    CAUSE_STEP_DONE = 3'd3,
    CAUSE_HOST      = 3'd4
  } halt_cause_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STEP   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } run_state_e;

  // Fetch must be held off in any state where the core is not allowed to advance.
  function automatic logic is_stall_state(input run_state_e s);
    return (s == ST_DRAIN) || (s == ST_HALTED);
  endfunction

endpackage

// File: rtl/dbg_run_ctrl.sv
// Run/halt sequencer between core retire port and debug probe: RUN/STEP/HALT, drain, one halt event.
// Latency: core_stall asserts the cycle after a halt cause; evt_valid rises on the edge that drain completes.
// Backpressure: cmd valid/ready (ready low in DRAIN and while an event is pending); evt held until evt_ready.
module dbg_run_ctrl
  import dbg_run_ctrl_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter bit HALT_ON_INVALID = 1'b1,
  parameter bit START_RUN       = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             retire_valid,
  input  logic [31:0]      retire_pc,
  input  logic [31:0]      retire_inst,
  input  logic             retire_ebreak,
  input  logic             retire_inval,
  input  logic             core_idle,
  output logic             core_stall,
  output logic             halted,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       halt_cause,
  output logic [31:0]      halt_pc,
  output logic [31:0]      halt_inst,
  output logic [CNT_W-1:0] step_left,
  output logic [CNT_W-1:0] inst_count,
  output logic             inv_seen
);

  localparam run_state_e RST_STATE = START_RUN ? ST_RUN : ST_HALTED;

  run_state_e       state_q,      state_d;
  logic             stall_q,      stall_d;
  logic             evt_valid_q,  evt_valid_d;
  halt_cause_e      halt_cause_q, halt_cause_d;
  logic [31:0]      halt_pc_q,    halt_pc_d;
  logic [31:0]      halt_inst_q,  halt_inst_d;
  logic [31:0]      last_pc_q,    last_pc_d;
  logic [31:0]      last_inst_q,  last_inst_d;
  logic [CNT_W-1:0] step_left_q,  step_left_d;
  logic [CNT_W-1:0] inst_count_q, inst_count_d;
  logic             inv_seen_q,   inv_seen_d;

  cmd_op_e     op;
  logic        cmd_fire;
  logic        inv_hit;
  logic        ebk_hit;
  logic        step_hit;
  logic        take_cause;
  halt_cause_e sel_cause;
  logic [31:0] sel_pc;
  logic [31:0] sel_inst;

  assign op = cmd_op_e'(cmd_op);

  // Commands are taken whenever the core may be redirected; never mid-drain or with an unread event.
  always_comb begin
    cmd_ready = 1'b0;
    case (state_q)
      ST_RUN, ST_STEP: cmd_ready = 1'b1;
      ST_HALTED:       cmd_ready = !evt_valid_q;
      default:         cmd_ready = 1'b0;
    endcase
  end

  assign cmd_fire = cmd_valid && cmd_ready;

  // Retire-side cause detection; only acted on while the core is running.
  always_comb begin
    inv_hit  = retire_valid && retire_inval && HALT_ON_INVALID;
    ebk_hit  = retire_valid && retire_ebreak;
    step_hit = (state_q == ST_STEP) && retire_valid && (step_left_q == CNT_W'(1));
  end

  // Next-state, counters, halt capture and event handshake.
  always_comb begin
    state_d      = state_q;
    evt_valid_d  = evt_valid_q;
    halt_cause_d = halt_cause_q;
    halt_pc_d    = halt_pc_q;
    halt_inst_d  = halt_inst_q;
    last_pc_d    = last_pc_q;
    last_inst_d  = last_inst_q;
    step_left_d  = step_left_q;
    inst_count_d = inst_count_q;
    inv_seen_d   = inv_seen_q;
    take_cause   = 1'b0;
    sel_cause    = CAUSE_NONE;
    sel_pc       = 32'd0;
    sel_inst     = 32'd0;

    // Every retire is counted, including skid retires after the stall went up.
    if (retire_valid) begin
      inst_count_d = inst_count_q + CNT_W'(1);
      last_pc_d    = retire_pc;
      last_inst_d  = retire_inst;
      if (retire_inval) begin
        inv_seen_d = 1'b1;
      end
    end

    case (state_q)
      ST_RUN, ST_STEP: begin
        if ((state_q == ST_STEP) && retire_valid && (step_left_q != '0)) begin
          step_left_d = step_left_q - CNT_W'(1);
        end
        if (inv_hit) begin
          take_cause = 1'b1;
          sel_cause  = CAUSE_INVALID;
          sel_pc     = retire_pc;
          sel_inst   = retire_inst;
        end else if (ebk_hit) begin
          take_cause = 1'b1;
          sel_cause  = CAUSE_EBREAK;
          sel_pc     = retire_pc;
          sel_inst   = retire_inst;
        end else if (step_hit) begin
          take_cause = 1'b1;
          sel_cause  = CAUSE_STEP_DONE;
          sel_pc     = retire_pc;
          sel_inst   = retire_inst;
        end else if (cmd_fire) begin
          case (op)
            OP_HALT: begin
              take_cause = 1'b1;
              sel_cause  = CAUSE_HOST;
              sel_pc     = last_pc_d;
              sel_inst   = last_inst_d;
            end
            OP_STEP: begin
              if (cmd_count == '0) begin
                take_cause = 1'b1;
                sel_cause  = CAUSE_STEP_DONE;
                sel_pc     = last_pc_d;
                sel_inst   = last_inst_d;
              end else begin
                state_d     = ST_STEP;
                step_left_d = cmd_count;
              end
            end
            OP_RUN:  state_d = ST_RUN;
            default: state_d = state_q;
          endcase
        end
      end

      ST_DRAIN: begin
        // Halted only once nothing is in flight and nothing retires this cycle.
        if (core_idle && !retire_valid) begin
          state_d     = ST_HALTED;
          evt_valid_d = 1'b1;
        end
      end

      ST_HALTED: begin
        if (evt_valid_q && evt_ready) begin
          evt_valid_d = 1'b0;
        end
        if (cmd_fire) begin
          case (op)
            OP_RUN: state_d = ST_RUN;
            OP_STEP: begin
              if (cmd_count == '0) begin
                take_cause = 1'b1;
                sel_cause  = CAUSE_STEP_DONE;
                sel_pc     = last_pc_d;
                sel_inst   = last_inst_d;
              end else begin
                state_d     = ST_STEP;
                step_left_d = cmd_count;
              end
            end
            default: state_d = state_q;
          endcase
        end
      end

      default: state_d = state_q;
    endcase

    // The first cause seen while running is the one reported; drain retires do not overwrite it.
    if (take_cause) begin
      state_d      = ST_DRAIN;
      halt_cause_d = sel_cause;
      halt_pc_d    = sel_pc;
      halt_inst_d  = sel_inst;
    end
  end

  assign stall_d = is_stall_state(state_d);

  // State and datapath registers; reset drops any pending event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RST_STATE;
      stall_q      <= !START_RUN;
      evt_valid_q  <= 1'b0;
      halt_cause_q <= CAUSE_NONE;
      halt_pc_q    <= 32'd0;
      halt_inst_q  <= 32'd0;
      last_pc_q    <= 32'd0;
      last_inst_q  <= 32'd0;
      step_left_q  <= '0;
      inst_count_q <= '0;
      inv_seen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_q      <= stall_d;
      evt_valid_q  <= evt_valid_d;
      halt_cause_q <= halt_cause_d;
      halt_pc_q    <= halt_pc_d;
      halt_inst_q  <= halt_inst_d;
      last_pc_q    <= last_pc_d;
      last_inst_q  <= last_inst_d;
      step_left_q  <= step_left_d;
      inst_count_q <= inst_count_d;
      inv_seen_q   <= inv_seen_d;
    end
  end

  assign core_stall = stall_q;
  assign halted     = (state_q == ST_HALTED);
  assign evt_valid  = evt_valid_q;
  assign halt_cause = halt_cause_q;
  assign halt_pc    = halt_pc_q;
  assign halt_inst  = halt_inst_q;
  assign step_left  = step_left_q;
  assign inst_count = inst_count_q;
  assign inv_seen   = inv_seen_q;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
module tb_dbg_run_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             retire_valid;
  logic [31:0]      retire_pc;
  logic [31:0]      retire_inst;
  logic             retire_ebreak;
  logic             retire_inval;
  logic             core_idle;
  logic             core_stall;
  logic             halted;
  logic             evt_valid;
  logic             evt_ready;
  logic [2:0]       halt_cause;
  logic [31:0]      halt_pc;
  logic [31:0]      halt_inst;
  logic [CNT_W-1:0] step_left;
  logic [CNT_W-1:0] inst_count;
  logic             inv_seen;

  // Second instance: invalid insts are only recorded, never halt.
  logic             u1_cmd_ready;
  logic             u1_core_stall;
  logic             u1_halted;
  logic             u1_evt_valid;
  logic [2:0]       u1_halt_cause;
  logic [31:0]      u1_halt_pc;
  logic [31:0]      u1_halt_inst;
  logic [CNT_W-1:0] u1_step_left;
  logic [CNT_W-1:0] u1_inst_count;
  logic             u1_inv_seen;

  dbg_run_ctrl #(.CNT_W(CNT_W), .HALT_ON_INVALID(1'b1), .START_RUN(1'b1)) u0 (
    .clk(clk), .reset(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_inst(retire_inst),
    .retire_ebreak(retire_ebreak), .retire_inval(retire_inval), .core_idle(core_idle),
    .core_stall(core_stall), .halted(halted), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .halt_cause(halt_cause), .halt_pc(halt_pc), .halt_inst(halt_inst),
    .step_left(step_left), .inst_count(inst_count), .inv_seen(inv_seen)
  );

  dbg_run_ctrl #(.CNT_W(CNT_W), .HALT_ON_INVALID(1'b0), .START_RUN(1'b1)) u1 (
    .clk(clk), .reset(rst_n),
    .cmd_valid(1'b0), .cmd_ready(u1_cmd_ready), .cmd_op(2'd0), .cmd_count('0),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_inst(retire_inst),
    .retire_ebreak(1'b0), .retire_inval(retire_inval), .core_idle(core_idle),
    .core_stall(u1_core_stall), .halted(u1_halted), .evt_valid(u1_evt_valid), .evt_ready(1'b1),
    .halt_cause(u1_halt_cause), .halt_pc(u1_halt_pc), .halt_inst(u1_halt_inst),
    .step_left(u1_step_left), .inst_count(u1_inst_count), .inv_seen(u1_inv_seen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  cause;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_evt_t;

  exp_evt_t exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted event is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL evt_unexpected: got cause %0d pc 0x%08h, expected no event", halt_cause, halt_pc);
      end else begin
        exp_evt_t e;
        e = exp_q.pop_front();
        chk("evt_cause", {29'd0, halt_cause}, {29'd0, e.cause});
        chk("evt_pc", halt_pc, e.pc);
        chk("evt_inst", halt_inst, e.inst);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] inst);
    exp_evt_t e;
    e.cause = c;
    e.pc    = pc;
    e.inst  = inst;
    exp_q.push_back(e);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] cnt);
    int waited;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    while (!cmd_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL cmd_ready_timeout: got cmd_ready=0 for 50 cycles, expected 1");
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] inst, input logic ebk, input logic inv);
    retire_valid  = 1'b1;
    retire_pc     = pc;
    retire_inst   = inst;
    retire_ebreak = ebk;
    retire_inval  = inv;
    tick();
    retire_valid  = 1'b0;
    retire_ebreak = 1'b0;
    retire_inval  = 1'b0;
  endtask

  task automatic wait_evt();
    int waited;
    waited = 0;
    while (!evt_valid && waited < 50) begin
      tick();
      waited++;
    end
    if (!evt_valid) begin
      n_vec++;
      n_miss++;
      $display("FAIL evt_timeout: got evt_valid=0 for 50 cycles, expected 1");
    end
  endtask

  task automatic accept_evt();
    wait_evt();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = '0;
    retire_valid = 1'b0; retire_pc = '0; retire_inst = '0;
    retire_ebreak = 1'b0; retire_inval = 1'b0; core_idle = 1'b1; evt_ready = 1'b0;

    // Reset state.
    tick(); tick();
    chk("rst_inst_count", inst_count, 32'd0);
    chk("rst_core_stall", {31'd0, core_stall}, 32'd0);
    chk("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_halt_cause", {29'd0, halt_cause}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Ten retires in RUN.
    for (int i = 0; i < 10; i++) retire(32'h1000 + 32'(4 * i), 32'h13, 1'b0, 1'b0);
    chk("run_inst_count", inst_count, 32'd10);
    chk("run_core_stall", {31'd0, core_stall}, 32'd0);
    chk("run_evt_valid", {31'd0, evt_valid}, 32'd0);
    chk("u1_inv_seen_clear", {31'd0, u1_inv_seen}, 32'd0);

    // Host halt from RUN reports the last retired inst.
    expect_evt(3'd4, 32'h1024, 32'h13);
    send_cmd(2'd2, 32'd0);
    chk("host_drain_stall", {31'd0, core_stall}, 32'd1);
    wait_evt();
    chk("host_halted", {31'd0, halted}, 32'd1);
    chk("host_cmd_ready_blocked", {31'd0, cmd_ready}, 32'd0);
    accept_evt();
    chk("host_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);

    // STEP 3 with five offers; the core model only retires while not stalled.
    send_cmd(2'd1, 32'd3);
    chk("step_loaded", step_left, 32'd3);
    chk("step_unstalled", {31'd0, core_stall}, 32'd0);
    expect_evt(3'd3, 32'h2008, 32'h102);
    for (int i = 0; i < 5; i++) begin
      if (!core_stall) retire(32'h2000 + 32'(4 * i), 32'h100 + 32'(i), 1'b0, 1'b0);
      else tick();
    end
    chk("step_inst_count", inst_count, 32'd13);
    chk("step_left_zero", step_left, 32'd0);
    chk("step_stall", {31'd0, core_stall}, 32'd1);
    accept_evt();

    // Ebreak in RUN with a skid retire during drain.
    send_cmd(2'd0, 32'd0);
    core_idle = 1'b0;
    expect_evt(3'd1, 32'h80000010, 32'h00100073);
    retire(32'h80000010, 32'h00100073, 1'b1, 1'b0);
    chk("ebk_stall_next", {31'd0, core_stall}, 32'd1);
    retire(32'h80000014, 32'h13, 1'b0, 1'b0);
    chk("ebk_skid_counted", inst_count, 32'd15);
    chk("ebk_pc_kept", halt_pc, 32'h80000010);
    tick(); tick();
    chk("ebk_drain_no_evt", {31'd0, evt_valid}, 32'd0);
    core_idle = 1'b1;
    wait_evt();
    tick(); tick(); tick();
    chk("ebk_evt_held", {31'd0, evt_valid}, 32'd1);
    accept_evt();

    // Invalid + ebreak + host halt together: invalid wins.
    send_cmd(2'd0, 32'd0);
    expect_evt(3'd2, 32'h3000, 32'hFFFFFFFF);
    cmd_valid = 1'b1; cmd_op = 2'd2;
    retire(32'h3000, 32'hFFFFFFFF, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    chk("inv_seen", {31'd0, inv_seen}, 32'd1);
    chk("inv_inst_count", inst_count, 32'd16);
    tick(); tick();
    chk("u1_not_halted", {31'd0, u1_halted}, 32'd0);
    chk("u1_no_stall", {31'd0, u1_core_stall}, 32'd0);
    chk("u1_inv_seen", {31'd0, u1_inv_seen}, 32'd1);
    accept_evt();

    // STEP 0 from HALTED: no instruction runs.
    expect_evt(3'd3, 32'h3000, 32'hFFFFFFFF);
    send_cmd(2'd1, 32'd0);
    chk("step0_drain_ready", {31'd0, cmd_ready}, 32'd0);
    wait_evt();
    tick();
    chk("step0_ready_blocked", {31'd0, cmd_ready}, 32'd0);
    chk("step0_inst_count", inst_count, 32'd16);
    accept_evt();
    chk("step0_ready_after", {31'd0, cmd_ready}, 32'd1);

    // Ebreak on the last step still reports EBREAK.
    send_cmd(2'd1, 32'd2);
    retire(32'h4000, 32'h13, 1'b0, 1'b0);
    chk("step2_left1", step_left, 32'd1);
    expect_evt(3'd1, 32'h4004, 32'h00100073);
    retire(32'h4004, 32'h00100073, 1'b1, 1'b0);
    chk("step2_left0", step_left, 32'd0);
    accept_evt();

    // HALT while halted: accepted, no new event.
    send_cmd(2'd2, 32'd0);
    tick(); tick(); tick();
    chk("halt_halt_no_evt", {31'd0, evt_valid}, 32'd0);
    chk("halt_halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_halt_cause_kept", {29'd0, halt_cause}, 32'd1);

    // Reset in the middle of a drain.
    send_cmd(2'd0, 32'd0);
    core_idle = 1'b0;
    send_cmd(2'd2, 32'd0);
    chk("mid_drain_cause", {29'd0, halt_cause}, 32'd4);
    chk("mid_drain_pc", halt_pc, 32'h4004);
    rst_n = 1'b0;
    #3;
    chk("rst_drain_evt", {31'd0, evt_valid}, 32'd0);
    chk("rst_drain_cause", {29'd0, halt_cause}, 32'd0);
    chk("rst_drain_count", inst_count, 32'd0);
    core_idle = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_halted", {31'd0, halted}, 32'd0);
    chk("post_rst_stall", {31'd0, core_stall}, 32'd0);
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    retire(32'h5000, 32'h13, 1'b0, 1'b0);
    chk("post_rst_count", inst_count, 32'd1);

    tick();
    chk("evt_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
